// File: rtl/mem_march_pkg.sv
// Shared types and the March C- element table for the RAM self-test controller.
package mem_march_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CHECK,
    WR_AFTER_RD,
    FINISH
  } state_t;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_expect_inv;
    logic has_write;
    logic write_inv;
  } elem_cfg_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0); codes 6/7 unused
  localparam elem_cfg_t ELEM_TBL [8] = '{
    5'b00010,
    5'b01011,
    5'b01110,
    5'b11011,
    5'b11110,
    5'b01000,
    5'b00000,
    5'b00000
  };

endpackage

// File: rtl/march_addr_seq.sv
// Address walker for one march element: load start address, step up or down, flag terminal address.
module march_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_c
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  // Address register; terminal test happens before any step so it never wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP_ADDR : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
  end

  assign last_c = down ? (addr == '0) : (addr == TOP_ADDR);

endmodule

// File: rtl/mem_march_bist.sv
// March C- BIST master for a single-port synchronous RAM; reports pass or the first failing read.
module mem_march_bist
  import mem_march_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 10,
  parameter int unsigned           MEM_SIZE   = 256,
  parameter logic [DATA_WIDTH-1:0] BG         = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FAIL_DATA,
  output logic [2:0]            FAIL_ELEM,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

  state_t                state, state_n;
  logic [2:0]            elem, elem_n;
  logic                  start_d;
  logic                  seq_load, seq_load_down, seq_step, last_c;
  logic                  addr_done_c;
  logic                  en_n, we_n, busy_n, done_n, pass_n;
  logic [DATA_WIDTH-1:0] din_n, fail_data_n;
  logic [ADDR_WIDTH-1:0] fail_addr_n;
  logic [2:0]            fail_elem_n;
  logic [DATA_WIDTH-1:0] exp_word_c;
  logic                  mismatch_c;

  march_addr_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_addr_seq (
    .CLK      (CLK),
    .RST      (RST),
    .load     (seq_load),
    .load_down(seq_load_down),
    .step     (seq_step),
    .down     (ELEM_TBL[elem].dir_down),
    .addr     (MEM_ADDR),
    .last_c   (last_c)
  );

  assign exp_word_c = ELEM_TBL[elem].read_expect_inv ? ~BG : BG;
  assign mismatch_c = (state == RD_CHECK) && (MEM_DOUT != exp_word_c);

  // Next-state, address sequencing and next values for every registered output.
  always_comb begin
    state_n       = state;
    elem_n        = elem;
    seq_load      = 1'b0;
    seq_load_down = 1'b0;
    seq_step      = 1'b0;
    addr_done_c   = 1'b0;
    done_n        = DONE;
    pass_n        = PASS;
    fail_addr_n   = FAIL_ADDR;
    fail_data_n   = FAIL_DATA;
    fail_elem_n   = FAIL_ELEM;

    case (state)
      IDLE: begin
        // Rising edge only, so a START held across a whole run triggers it once.
        if (START && !start_d) begin
          elem_n        = E0;
          seq_load      = 1'b1;
          seq_load_down = ELEM_TBL[E0].dir_down;
          state_n       = ELEM_TBL[E0].has_read ? RD_ISSUE : WR;
          done_n        = 1'b0;
          pass_n        = 1'b0;
          fail_addr_n   = '0;
          fail_data_n   = '0;
          fail_elem_n   = '0;
        end
      end
      WR:       addr_done_c = 1'b1;
      RD_ISSUE: state_n = RD_CHECK;
      RD_CHECK: begin
        if (mismatch_c) begin
          state_n     = FINISH;
          done_n      = 1'b1;
          pass_n      = 1'b0;
          fail_addr_n = MEM_ADDR;
          fail_data_n = MEM_DOUT;
          fail_elem_n = elem;
        end else if (ELEM_TBL[elem].has_write) begin
          state_n = WR_AFTER_RD;
        end else begin
          addr_done_c = 1'b1;
        end
      end
      WR_AFTER_RD: addr_done_c = 1'b1;
      FINISH:      state_n = IDLE;
      default:     state_n = IDLE;
    endcase

    // Last operation on this address: step within the element, move to the next one, or finish.
    if (addr_done_c) begin
      if (!last_c) begin
        seq_step = 1'b1;
        state_n  = ELEM_TBL[elem].has_read ? RD_ISSUE : WR;
      end else if (elem == E5) begin
        state_n = FINISH;
        done_n  = 1'b1;
        pass_n  = 1'b1;
      end else begin
        elem_n        = elem + 3'd1;
        seq_load      = 1'b1;
        seq_load_down = ELEM_TBL[elem_n].dir_down;
        state_n       = ELEM_TBL[elem_n].has_read ? RD_ISSUE : WR;
      end
    end

    en_n   = state_n inside {WR, RD_ISSUE, RD_CHECK, WR_AFTER_RD};
    we_n   = state_n inside {WR, WR_AFTER_RD};
    busy_n = en_n;
    din_n  = '0;
    if (we_n) begin
      din_n = ELEM_TBL[elem_n].write_inv ? ~BG : BG;
    end
  end

  // State, element and output registers; reset aborts any run in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      elem      <= E0;
      start_d   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_DATA <= '0;
      FAIL_ELEM <= '0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_DIN   <= '0;
    end else begin
      state     <= state_n;
      elem      <= elem_n;
      start_d   <= START;
      BUSY      <= busy_n;
      DONE      <= done_n;
      PASS      <= pass_n;
      FAIL_ADDR <= fail_addr_n;
      FAIL_DATA <= fail_data_n;
      FAIL_ELEM <= fail_elem_n;
      MEM_EN    <= en_n;
      MEM_WE    <= we_n;
      MEM_DIN   <= din_n;
    end
  end

endmodule

// File: tb/tb_mem_march_bist.sv
// Scoreboard bench for mem_march_bist: a behavioural March C- model predicts every access and the final status.
module tb_mem_march_bist;

  logic       CLK = 1'b0;
  logic       RST;
  logic       go;
  int         sel;
  int         fault_mode;

  always #5 CLK = ~CLK;

  logic       start4, start5;
  logic       b4, d4, p4, en4, we4;
  logic [7:0] fa4, ad4;
  logic [9:0] fd4, di4;
  logic [2:0] fe4;
  logic       b5, d5, p5, en5, we5;
  logic [2:0] fa5, ad5;
  logic [9:0] fd5, di5;
  logic [2:0] fe5;
  logic [9:0] r_dout;

  assign start4 = go && (sel == 0);
  assign start5 = go && (sel == 1);

  mem_march_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(10), .MEM_SIZE(4), .BG(10'h000)) dut (
    .CLK(CLK), .RST(RST), .START(start4), .BUSY(b4), .DONE(d4), .PASS(p4),
    .FAIL_ADDR(fa4), .FAIL_DATA(fd4), .FAIL_ELEM(fe4),
    .MEM_EN(en4), .MEM_WE(we4), .MEM_ADDR(ad4), .MEM_DIN(di4), .MEM_DOUT(r_dout)
  );

  mem_march_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(10), .MEM_SIZE(5), .BG(10'h000)) dut5 (
    .CLK(CLK), .RST(RST), .START(start5), .BUSY(b5), .DONE(d5), .PASS(p5),
    .FAIL_ADDR(fa5), .FAIL_DATA(fd5), .FAIL_ELEM(fe5),
    .MEM_EN(en5), .MEM_WE(we5), .MEM_ADDR(ad5), .MEM_DIN(di5), .MEM_DOUT(r_dout)
  );

  // Signals of whichever DUT is under test
  logic        m_busy, m_done, m_pass, m_en, m_we;
  logic [7:0]  m_addr, m_fa;
  logic [9:0]  m_din, m_fd;
  logic [2:0]  m_fe;
  logic [43:0] m_all;

  assign m_busy = (sel == 1) ? b5  : b4;
  assign m_done = (sel == 1) ? d5  : d4;
  assign m_pass = (sel == 1) ? p5  : p4;
  assign m_en   = (sel == 1) ? en5 : en4;
  assign m_we   = (sel == 1) ? we5 : we4;
  assign m_addr = (sel == 1) ? {5'd0, ad5} : ad4;
  assign m_fa   = (sel == 1) ? {5'd0, fa5} : fa4;
  assign m_din  = (sel == 1) ? di5 : di4;
  assign m_fd   = (sel == 1) ? fd5 : fd4;
  assign m_fe   = (sel == 1) ? fe5 : fe4;
  assign m_all  = {m_busy, m_done, m_pass, m_en, m_we, m_addr, m_din, m_fa, m_fd, m_fe};

  // RAM model with optional faults: 1 = bit0 stuck-at-1 at addr 2, 2 = write to addr 1 inverts addr 3
  logic [9:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[8'(i)] = 10'h000;
    r_dout = 10'h000;
  end

  always @(posedge CLK) begin
    if (m_en) begin
      if (m_we) begin
        ram[m_addr] <= (fault_mode == 1 && m_addr == 8'd2) ? (m_din | 10'h001) : m_din;
        if (fault_mode == 2 && m_addr == 8'd1) ram[3] <= ~ram[3];
      end else begin
        r_dout <= ram[m_addr];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [19:0] exp_q [$];
  int x_pass, x_addr, x_data, x_elem, x_cycles;

  // Reference March C- walk over a model RAM with the same fault, predicting accesses and result
  task automatic build_expect(input int msize, input int fault);
    logic [9:0] mm [0:7];
    logic [9:0] rd, wv, rv;
    int a;
    exp_q.delete();
    x_pass = 1; x_addr = 0; x_data = 0; x_elem = 0; x_cycles = 0;
    for (int i = 0; i < 8; i++) mm[3'(i)] = 10'h000;
    for (int e = 0; e < 6; e++) begin
      wv = (e == 1 || e == 3) ? 10'h3FF : 10'h000;
      rv = (e == 2 || e == 4) ? 10'h3FF : 10'h000;
      for (int i = 0; i < msize; i++) begin
        if (x_pass != 0) begin
          a = (e == 3 || e == 4) ? msize - 1 - i : i;
          if (e != 0) begin
            rd = mm[3'(a)];
            repeat (2) exp_q.push_back({1'b1, 1'b0, 8'(a), 10'h000});
            x_cycles += 2;
            if (rd != rv) begin
              x_pass = 0; x_addr = a; x_data = int'(rd); x_elem = e;
            end
          end
          if (x_pass != 0 && e != 5) begin
            exp_q.push_back({1'b1, 1'b1, 8'(a), wv});
            x_cycles++;
            mm[3'(a)] = (fault == 1 && a == 2) ? (wv | 10'h001) : wv;
            if (fault == 2 && a == 1) mm[3] = ~mm[3];
          end
        end
      end
    end
  endtask

  // One run: pulse (or hold) START, compare every busy cycle against the queue, then the status
  task automatic run(input int s, input int msize, input int fault, input bit hold, input int rst_at);
    int cyc;
    logic [19:0] e;
    sel = s;
    fault_mode = fault;
    build_expect(msize, fault);
    @(negedge CLK);
    go = 1'b1;
    @(negedge CLK);
    if (!hold) go = 1'b0;
    cyc = 0;
    while (m_busy === 1'b1 && cyc < 2000) begin
      if (cyc == 0) check("clear_on_start", 64'({m_done, m_pass, m_fa, m_fd, m_fe}), '0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 20'hFFFFF;
      check("access", 64'({m_en, m_we, m_addr, (m_we ? m_din : 10'd0)}), 64'(e));
      cyc++;
      if (rst_at != 0 && cyc == rst_at) begin
        RST = 1'b1;
        @(negedge CLK);
        check("rst_abort", 64'(m_all), '0);
        RST = 1'b0;
        go  = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          check("rst_no_access", 64'({m_busy, m_en, m_we}), '0);
        end
        return;
      end
      @(negedge CLK);
    end
    check("busy_cycles", 64'(cyc), 64'(x_cycles));
    check("done", 64'(m_done), 64'(1));
    check("pass", 64'(m_pass), 64'(x_pass));
    check("fail_addr", 64'(m_fa), 64'(x_addr));
    check("fail_data", 64'(m_fd), 64'(x_data));
    check("fail_elem", 64'(m_fe), 64'(x_elem));
    check("queue_empty", 64'(exp_q.size()), '0);
    repeat (hold ? 5 : 2) begin
      @(negedge CLK);
      check("idle_hold", 64'({m_busy, m_en, m_done, m_pass, m_fe}),
            64'({1'b0, 1'b0, 1'b1, x_pass[0], x_elem[2:0]}));
    end
    go = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    go = 1'b0;
    sel = 0;
    fault_mode = 0;
    repeat (3) @(negedge CLK);
    check("reset_state", 64'(m_all), '0);
    sel = 1;
    #1;
    check("reset_state5", 64'(m_all), '0);
    sel = 0;
    RST = 1'b0;

    run(0, 4, 0, 1'b0, 0);   // clean run, 60 busy cycles
    run(0, 4, 1, 1'b0, 0);   // stuck-at-1 at addr 2
    run(0, 4, 2, 1'b0, 0);   // coupling 1 -> 3
    run(0, 4, 0, 1'b1, 0);   // START held through run; restart after a failure
    run(0, 4, 0, 1'b0, 0);   // re-START after DONE
    run(0, 4, 0, 1'b0, 20);  // reset mid-run
    run(0, 4, 0, 1'b0, 0);   // clean run after abort
    run(1, 5, 0, 1'b0, 0);   // MEM_SIZE=5 in a 3-bit address space
    run(1, 5, 2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
